// File: rtl/pushbutton_debouncer_pkg.sv
// Shared types and limits for the push-button debouncer.
package pushbutton_pkg;
  typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} db_state_t;
  localparam int DB_MIN_CYCLES  = 2;
  localparam int RPT_MIN_CYCLES = 2;
endpackage

// File: rtl/pushbutton_debouncer_if.sv
// Button pin plus conditioned outputs; master drives the pin, slave is the debouncer.
interface pushbutton_debouncer_if;
  logic btn_in;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_pending;
  modport master (output btn_in, input btn_level, btn_press, btn_release, btn_pending);
  modport slave  (input btn_in, output btn_level, btn_press, btn_release, btn_pending);
endinterface

// File: rtl/pushbutton_debouncer_sync_2ff.sv
// Two-flop synchronizer, reset value 0, nothing between the flops.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pushbutton_debouncer.sv
// Debounces a raw push-button into level / press / release / pending signals.
// Optional auto-repeat of btn_press while held: define PUSHBUTTON_REPEAT_EN.
module pushbutton_debouncer
  import pushbutton_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter bit ACTIVE_LOW_IN   = 1'b0,
  parameter int REPEAT_CYCLES   = 64
) (
  input logic clk,
  input logic rst_n,
  pushbutton_debouncer_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < DB_MIN_CYCLES) begin : g_bad_cycles
    $error("DEBOUNCE_CYCLES below minimum");
  end
  if (CNT_W != $clog2(DEBOUNCE_CYCLES + 1)) begin : g_bad_width
    $error("CNT_W must not be overridden");
  end

  logic raw, s;
  assign raw = ACTIVE_LOW_IN ? ~bus.btn_in : bus.btn_in;

  sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(raw), .q(s));

  db_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             level_r, press_r, release_r, pending_r;

`ifdef PUSHBUTTON_REPEAT_EN
  localparam int RPT_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rpt_cnt;
  if (REPEAT_CYCLES < RPT_MIN_CYCLES) begin : g_bad_rpt
    $error("REPEAT_CYCLES below minimum");
  end
`endif

  // Output registers are updated alongside the state so they track it with no extra lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_LOW;
      cnt       <= '0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      pending_r <= 1'b0;
`ifdef PUSHBUTTON_REPEAT_EN
      rpt_cnt   <= '0;
`endif
    end else begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
`ifdef PUSHBUTTON_REPEAT_EN
      rpt_cnt   <= '0;
`endif
      case (state)
        S_LOW: begin
          if (s) begin
            state     <= S_RISE;
            cnt       <= CNT_W'(1);
            pending_r <= 1'b1;
          end
        end
        S_RISE: begin
          if (!s) begin
            state     <= S_LOW;
            cnt       <= '0;
            pending_r <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state     <= S_HIGH;
            cnt       <= '0;
            press_r   <= 1'b1;
            level_r   <= 1'b1;
            pending_r <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (!s) begin
            state     <= S_FALL;
            cnt       <= CNT_W'(1);
            pending_r <= 1'b1;
          end
`ifdef PUSHBUTTON_REPEAT_EN
          else if (rpt_cnt == RPT_LAST) begin
            press_r <= 1'b1;
          end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
          end
`endif
        end
        S_FALL: begin
          if (s) begin
            state     <= S_HIGH;
            cnt       <= '0;
            pending_r <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state     <= S_LOW;
            cnt       <= '0;
            release_r <= 1'b1;
            level_r   <= 1'b0;
            pending_r <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= S_LOW;
          cnt       <= '0;
          level_r   <= 1'b0;
          pending_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.btn_level   = level_r;
  assign bus.btn_press   = press_r;
  assign bus.btn_release = release_r;
  assign bus.btn_pending = pending_r;
endmodule
